// File: rtl/mmio_io_responder.sv
// mmio_io_responder
//   Responder for the CPU byte-bus I/O window. CPU output bytes are queued in a
//   TX FIFO toward the UART transmitter. Host input bytes are queued in an RX
//   FIFO for CPU reads. Read data appears on d_out one cycle after the request,
//   which matches RAM read timing.
//
//   Optional feature: define IO_CYCLE_CNT_EN to add a 32-bit free-running cycle
//   counter. Reading sel2 returns cnt[7:0] and snapshots cnt[31:8]. Reading
//   sel3/sel6/sel7 returns snapshot bytes 1/2/3. Without the macro, these
//   selects read as 8'h00.
//
// Ports
//   clk_in, rst_n_in    clock, asynchronous active-low reset
//   rdy_in, en_in       bus valid and I/O window select; access = rdy_in & en_in
//   a_in, wr_in, d_in   register select, write strobe, write data
//   d_out               registered read data
//   io_full_out         TX FIFO full
//   tx_data_out/valid   TX FIFO head toward UART; popped on valid & tx_ready_in
//   rx_data_in/valid    UART RX byte; taken on valid & rx_ready_out
//   rx_ready_out        RX FIFO not full
//   program_finish_out  one-cycle pulse after a sel4 write
module mmio_io_responder #(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  input  logic       en_in,
  input  logic [2:0] a_in,
  input  logic       wr_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       io_full_out,
  output logic [7:0] tx_data_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_valid_in,
  output logic       rx_ready_out,
  output logic       program_finish_out
);

  localparam int unsigned TXW      = TX_DEPTH_LOG2;
  localparam int unsigned RXW      = RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TXW;
  localparam int unsigned RX_DEPTH = 1 << RXW;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_rd;
  logic [TXW:0]   tx_cnt;
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_rd;
  logic [RXW:0]   rx_cnt;
  logic         ovf;

  logic acc, wr_acc, rd_acc;
  logic tx_full, rx_nonempty;
  logic tx_push_req, tx_push, tx_pop, ovf_set;
  logic rx_push, rx_pop;
  logic [TXW-1:0] tx_wr_idx;
  logic [RXW-1:0] rx_wr_idx;
  logic [7:0] rd_data;

  // Bus decode and FIFO handshakes
  always_comb begin
    acc          = rdy_in & en_in;
    wr_acc       = acc & wr_in;
    rd_acc       = acc & ~wr_in;
    tx_full      = (tx_cnt == (TXW+1)'(TX_DEPTH));
    rx_nonempty  = (rx_cnt != '0);
    io_full_out  = tx_full;
    tx_valid_out = (tx_cnt != '0);
    rx_ready_out = (rx_cnt != (RXW+1)'(RX_DEPTH));
    tx_data_out  = tx_valid_out ? tx_mem[tx_rd] : 8'h00;
    tx_pop       = tx_valid_out & tx_ready_in;
    tx_push_req  = wr_acc & (a_in == 3'd0);
    // A same-cycle pop frees the head slot, so a full FIFO can still accept
    tx_push      = tx_push_req & (~tx_full | tx_pop);
    ovf_set      = tx_push_req & tx_full & ~tx_pop;
    rx_push      = rx_valid_in & rx_ready_out;
    rx_pop       = rd_acc & (a_in == 3'd0) & rx_nonempty;
    // Tail index wraps naturally in the pointer width
    tx_wr_idx    = tx_rd + tx_cnt[TXW-1:0];
    rx_wr_idx    = rx_rd + rx_cnt[RXW-1:0];
  end

`ifdef IO_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
  logic [23:0] cyc_snap;

  // Free-running counter plus snapshot of the upper bytes on sel2 reads
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cyc_cnt  <= '0;
      cyc_snap <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_acc && (a_in == 3'd2)) cyc_snap <= cyc_cnt[31:8];
    end
  end
`endif

  // Read mux, evaluated on pre-edge state
  always_comb begin
    rd_data = 8'h00;
    case (a_in)
      3'd0:    rd_data = rx_nonempty ? rx_mem[rx_rd] : 8'h00;
      3'd4:    rd_data = {5'b0, ovf, rx_nonempty, tx_full};
`ifdef IO_CYCLE_CNT_EN
      3'd2:    rd_data = cyc_cnt[7:0];
      3'd3:    rd_data = cyc_snap[7:0];
      3'd6:    rd_data = cyc_snap[15:8];
      3'd7:    rd_data = cyc_snap[23:16];
`endif
      default: rd_data = 8'h00;
    endcase
  end

  // FIFO storage (contents need no reset; counts define validity)
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_idx] <= d_in;
    if (rx_push) rx_mem[rx_wr_idx] <= rx_data_in;
  end

  // Pointers, counts, status and registered bus outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_rd              <= '0;
      tx_cnt             <= '0;
      rx_rd              <= '0;
      rx_cnt             <= '0;
      ovf                <= 1'b0;
      d_out              <= 8'h00;
      program_finish_out <= 1'b0;
    end else begin
      if (tx_pop) tx_rd <= tx_rd + TXW'(1);
      tx_cnt <= tx_cnt + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
      if (rx_pop) rx_rd <= rx_rd + RXW'(1);
      rx_cnt <= rx_cnt + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
      if (ovf_set) ovf <= 1'b1;
      else if (wr_acc && (a_in == 3'd4) && d_in[7]) ovf <= 1'b0;
      if (rd_acc) d_out <= rd_data;
      program_finish_out <= wr_acc & (a_in == 3'd4);
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Testbench for mmio_io_responder: directed scenarios followed by randomized
// traffic. A queue-based behavioural model predicts read data, TX byte order,
// flags and finish pulses. Independent monitors compare the DUT against these
// predictions.
module tb_mmio_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       rdy_in, en_in, wr_in;
  logic [2:0] a_in;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       io_full_out;
  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_ready_in;
  logic [7:0] rx_data_in;
  logic       rx_valid_in;
  logic       rx_ready_out;
  logic       program_finish_out;

  mmio_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .en_in(en_in),
    .a_in(a_in), .wr_in(wr_in), .d_in(d_in), .d_out(d_out),
    .io_full_out(io_full_out), .tx_data_out(tx_data_out),
    .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .rx_ready_out(rx_ready_out), .program_finish_out(program_finish_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [7:0]  exp_q[$];    // expected d_out per accepted read
  logic [7:0]  txexp_q[$];  // bytes expected on the TX side, in order
  logic [7:0]  rx_q[$];     // RX FIFO contents
  int          tx_cnt = 0;
  logic        ovf = 1'b0;
  logic [31:0] mcnt = '0;
  logic [23:0] msnap = '0;
  logic        fin_next = 1'b0;

  // Monitor state
  logic       rd_seen = 1'b0;
  logic       fin_cur = 1'b0;
  logic [7:0] last_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Check flags against the model, predict the next edge, then advance one cycle
  task automatic step();
    logic       acc, tx_pop;
    logic [7:0] r;
    int         rx_n;
    fin_next = 1'b0;
    if (rst_n_in) begin
      chk("io_full", 32'(io_full_out), 32'(tx_cnt == 16));
      chk("tx_valid", 32'(tx_valid_out), 32'(tx_cnt > 0));
      chk("rx_ready", 32'(rx_ready_out), 32'(rx_q.size() < 16));
      acc    = rdy_in & en_in;
      tx_pop = (tx_cnt > 0) && tx_ready_in;
      rx_n   = rx_q.size();
      r      = 8'h00;
      if (acc && !wr_in) begin
        case (a_in)
          3'd0: if (rx_n > 0) r = rx_q.pop_front();
          3'd4: r = {5'b0, ovf, rx_n > 0, tx_cnt == 16};
`ifdef IO_CYCLE_CNT_EN
          3'd2: begin r = mcnt[7:0]; msnap = mcnt[31:8]; end
          3'd3: r = msnap[7:0];
          3'd6: r = msnap[15:8];
          3'd7: r = msnap[23:16];
`endif
          default: r = 8'h00;
        endcase
        exp_q.push_back(r);
      end
      if (acc && wr_in) begin
        if (a_in == 3'd0) begin
          if (tx_cnt < 16 || tx_pop) begin
            txexp_q.push_back(d_in);
            tx_cnt++;
          end else begin
            ovf = 1'b1;
          end
        end
        if (a_in == 3'd4) begin
          fin_next = 1'b1;
          if (d_in[7]) ovf = 1'b0;
        end
      end
      if (tx_pop) tx_cnt--;
      if (rx_valid_in && rx_n < 16) rx_q.push_back(rx_data_in);
      mcnt = mcnt + 32'd1;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic drive(input logic rdy, input logic en, input logic wr,
                       input logic [2:0] a, input logic [7:0] d);
    rdy_in = rdy; en_in = en; wr_in = wr; a_in = a; d_in = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    #1;
    chk("rst_d_out", 32'(d_out), 32'h0);
    chk("rst_io_full", 32'(io_full_out), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid_out), 32'h0);
    chk("rst_tx_data", 32'(tx_data_out), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready_out), 32'h1);
    chk("rst_finish", 32'(program_finish_out), 32'h0);
    tx_cnt = 0; ovf = 1'b0; mcnt = '0; msnap = '0;
    txexp_q.delete(); rx_q.delete(); exp_q.delete();
    idle(2);
    rst_n_in = 1'b1;
  endtask

  // Capture what the DUT sees at each active edge
  always @(posedge clk_in) begin
    rd_seen = rst_n_in & rdy_in & en_in & ~wr_in;
    fin_cur = fin_next;
  end

  // Scoreboard monitor: compare outputs mid-cycle, away from the active edge
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      last_dout = 8'h00;
    end else begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dout_unexpected: read seen with no prediction, d_out=0x%0h", d_out);
        end else begin
          last_dout = exp_q.pop_front();
          chk("dout", 32'(d_out), 32'(last_dout));
        end
      end else begin
        chk("dout_hold", 32'(d_out), 32'(last_dout));
      end
      chk("finish_pulse", 32'(program_finish_out), 32'(fin_cur));
      if (tx_valid_out && tx_ready_in) begin
        if (txexp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: pop with no prediction, tx_data=0x%0h", tx_data_out);
        end else begin
          chk("tx_data", 32'(tx_data_out), 32'(txexp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b0; en_in = 1'b0; wr_in = 1'b0;
    a_in = 3'd0; d_in = 8'h00; tx_ready_in = 1'b0;
    rx_data_in = 8'h00; rx_valid_in = 1'b0;
    @(posedge clk_in); #1;
    apply_reset();

    // TX ordering
    drive(1, 1, 1, 3'd0, 8'h41);
    drive(1, 1, 1, 3'd0, 8'h42);
    drive(1, 1, 1, 3'd0, 8'h43);
    tx_ready_in = 1'b1;
    idle(5);
    tx_ready_in = 1'b0;

    // TX full, overflow, overflow clear
    for (int i = 0; i < 16; i++) drive(1, 1, 1, 3'd0, 8'(i + 8'h10));
    drive(1, 1, 1, 3'd0, 8'hEE);
    drive(1, 1, 0, 3'd4, 8'h00);
    drive(1, 1, 1, 3'd4, 8'h80);
    drive(1, 1, 0, 3'd4, 8'h00);
    tx_ready_in = 1'b1;
    idle(18);

    // RX single byte, then read from empty
    rx_data_in = 8'h5A; rx_valid_in = 1'b1;
    idle(1);
    rx_valid_in = 1'b0;
    drive(1, 1, 0, 3'd0, 8'h00);
    drive(1, 1, 0, 3'd0, 8'h00);
    drive(1, 1, 0, 3'd4, 8'h00);

    // Simultaneous push and pop on a full TX FIFO and on a one-byte RX FIFO
    tx_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) drive(1, 1, 1, 3'd0, 8'(8'hA0 + i));
    tx_ready_in = 1'b1;
    drive(1, 1, 1, 3'd0, 8'hB7);
    tx_ready_in = 1'b0;
    drive(1, 1, 0, 3'd4, 8'h00);
    rx_data_in = 8'h11; rx_valid_in = 1'b1;
    idle(1);
    rx_data_in = 8'h22;
    drive(1, 1, 0, 3'd0, 8'h00);
    rx_valid_in = 1'b0;
    drive(1, 1, 0, 3'd4, 8'h00);
    drive(1, 1, 0, 3'd0, 8'h00);
    tx_ready_in = 1'b1;
    idle(18);

    // Bus gating and finish pulse
    drive(0, 1, 1, 3'd0, 8'h77);
    drive(1, 0, 1, 3'd0, 8'h78);
    drive(0, 1, 0, 3'd4, 8'h00);
    drive(1, 0, 0, 3'd4, 8'h00);
    drive(1, 1, 1, 3'd4, 8'h00);
    idle(2);

    // Counter and unused selects
    drive(1, 1, 0, 3'd2, 8'h00);
    drive(1, 1, 0, 3'd3, 8'h00);
    drive(1, 1, 0, 3'd6, 8'h00);
    drive(1, 1, 0, 3'd7, 8'h00);
    drive(1, 1, 0, 3'd1, 8'h00);
    drive(1, 1, 0, 3'd5, 8'h00);

    // Reset with bytes queued in both FIFOs
    tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 3'd0, 8'(8'hC0 + i));
    rx_data_in = 8'h33; rx_valid_in = 1'b1;
    idle(2);
    rx_valid_in = 1'b0;
    idle(2);
    apply_reset();
    drive(1, 1, 0, 3'd4, 8'h00);
    drive(1, 1, 0, 3'd0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4);
      tx_ready_in = ($urandom_range(0, 2) == 0);
      rx_valid_in = ($urandom_range(0, 1) == 0);
      rx_data_in  = 8'($urandom);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 0, a, 8'($urandom));
    end

    // Drain and confirm every prediction was consumed
    rx_valid_in = 1'b0;
    tx_ready_in = 1'b1;
    idle(20);
    chk("reads_drained", 32'(exp_q.size()), 32'h0);
    chk("tx_drained", 32'(txexp_q.size()), 32'h0);
    chk("tx_empty_end", 32'(tx_valid_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
